data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, word width in bits; multiple of 8, min 8.
REQ-002 SHALL provide parameter DEPTH, default 512, number of words; power of two.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_be, input, DATA_WIDTH/8, byte-lane write enables; bit i covers data bits [8i+7:8i].
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH, byte address.
REQ-011 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-012 SHALL have port resp_valid, output, 1, one-cycle response pulse.
REQ-013 SHALL have port resp_rdata, output, DATA_WIDTH, read data; valid with resp_valid.
REQ-014 SHALL have port resp_err, output, 1, request error flag; valid with resp_valid.
REQ-015 SHALL have port init_done, output, 1, high once memory is usable.

Function
REQ-016 SHALL accept one request per cycle when req_valid and req_ready are both high (the handshake).
REQ-017 SHALL assert resp_valid exactly one cycle after each accepted request, for exactly one cycle; fully pipelined, back-to-back requests give back-to-back responses.
REQ-018 SHALL compute word index = req_addr >> log2(DATA_WIDTH/8).
REQ-019 SHALL flag misaligned: any of req_addr[log2(DATA_WIDTH/8)-1:0] nonzero -> resp_err=1, no write, resp_rdata=0.
REQ-020 SHALL flag out of range: word index >= DEPTH -> resp_err=1, no write, resp_rdata=0.
REQ-021 SHALL, on a valid write, update only lanes with req_be bit set; other lanes keep old value; resp_rdata=0, resp_err=0.
REQ-022 SHALL, on a write with req_be all zero, change no memory and give resp_err=0.
REQ-023 SHALL, on a valid read, return the word as stored at the accept edge; a read accepted the cycle after a write to the same word returns the written data.
REQ-024 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid is 0.
REQ-025 SHALL implement states INIT and RUN; INIT -> RUN when sweep counter reaches DEPTH-1 (or immediately per REQ-032); RUN holds until reset.
REQ-026 SHALL drive req_ready = 1 and init_done = 1 only in RUN; requests presented in INIT are not accepted and produce no response.

Reset
REQ-027 SHALL, while rst is high, asynchronously force state=INIT, sweep counter=0, req_ready=0, init_done=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 SHALL, on reset asserted mid-operation, discard any pending response (no resp_valid after reset release for a pre-reset request).
REQ-029 SHALL leave memory contents unaffected by the rst assertion itself; clearing occurs only per REQ-031.

Configuration
REQ-030 SHALL use macro RAM_CLEAR_ON_RESET_EN to select post-reset clearing.
REQ-031 SHALL, with RAM_CLEAR_ON_RESET_EN defined, zero one word per cycle in INIT, index 0 to DEPTH-1 in order, entering RUN the cycle after writing word DEPTH-1 (DEPTH cycles of INIT after reset release).
REQ-032 SHALL, without RAM_CLEAR_ON_RESET_EN, enter RUN on the first clock edge after reset release with memory contents unchanged.

Verification
REQ-033 SHALL verify: macro on, DEPTH=512, release reset -> req_ready=0 for 512 cycles, then high; read addr 0x7FC -> resp_rdata=0x00000000, resp_err=0.
REQ-034 SHALL verify: write addr 0x10, wdata 0xAABBCCDD, be=4'b1111; then write addr 0x10, wdata 0x11223344, be=4'b0101; read 0x10 -> 0xAA22CC44.
REQ-035 SHALL verify: read addr 0x12 -> resp_err=1, resp_rdata=0; read addr 0x800 (DEPTH=512) -> resp_err=1; write to 0x800 leaves word 0 unchanged.
REQ-036 SHALL verify: write 0x20=0xDEADBEEF accepted cycle N, read 0x20 accepted cycle N+1 -> resp_valid at N+2 with 0xDEADBEEF; resp_valid high N+1 and N+2.
REQ-037 SHALL verify: assert rst in cycle a read is accepted -> no resp_valid after release; macro off -> req_ready=1 one cycle after release, prior contents intact.
REQ-038 SHALL verify: DATA_WIDTH=64, DEPTH=16: write 0x08, be=8'h80, wdata 0xFF00...0 -> read 0x08 upper byte 0xFF; addr 0x04 -> resp_err=1.

Source files
------------

// File: rtl/data_ram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_ram_ctrl: byte-enabled single-port data RAM, one-cycle response.    |
// | Option: RAM_CLEAR_ON_RESET_EN zeroes the array after reset. Rev 1.0      |
// +--------------------------------------------------------------------------+
module data_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    init_done
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        sweep_q, sweep_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]        w_idx;
    logic [ADDR_WIDTH-1:0]   w_hi;
    logic                    w_misalign;
    logic                    w_oor;
    logic                    w_err;
    logic                    w_accept;
    logic                    w_wr;
    logic                    w_clear;

    // Any address bit above the word index means the word lies past DEPTH.
    assign w_idx      = req_addr[OFF_W +: IDX_W];
    assign w_hi       = req_addr >> (OFF_W + IDX_W);
    assign w_misalign = |(req_addr & OFF_MASK);
    assign w_oor      = |w_hi;
    assign w_err      = w_misalign | w_oor;

    assign req_ready  = (state_q == ST_RUN);
    assign init_done  = (state_q == ST_RUN);
    assign w_accept   = req_valid & req_ready;
    assign w_wr       = w_accept & req_we & ~w_err;

`ifdef RAM_CLEAR_ON_RESET_EN
    assign w_clear = (state_q == ST_INIT) & ~rst;
`else
    assign w_clear = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
`ifdef RAM_CLEAR_ON_RESET_EN
            if (sweep_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                sweep_d = sweep_q + IDX_W'(1);
            end
`else
            state_d = ST_RUN;
`endif
        end
    end

    always_comb begin
        resp_valid_d = w_accept;
        resp_err_d   = w_accept & w_err;
        resp_rdata_d = '0;
        if (w_accept && !req_we && !w_err) begin
            resp_rdata_d = mem_q[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // The array has no reset; only the post-reset sweep may clear it.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            mem_q[sweep_q] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_ram_ctrl: randomized + directed bench with a word-array model.   |
// | Honours RAM_CLEAR_ON_RESET_EN when defined. Rev 1.0                      |
// +--------------------------------------------------------------------------+
module tb_data_ram_ctrl;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_valid = 1'b0;
    logic        r_we = 1'b0;
    logic [3:0]  r_be = '0;
    logic [31:0] r_addr = '0;
    logic [31:0] r_wdata = '0;
    logic        w_ready, w_rvalid, w_err, w_done;
    logic [31:0] w_rdata;

    logic        r64_valid = 1'b0;
    logic        r64_we = 1'b0;
    logic [7:0]  r64_be = '0;
    logic [31:0] r64_addr = '0;
    logic [63:0] r64_wdata = '0;
    logic        w64_ready, w64_rvalid, w64_err, w64_done;
    logic [63:0] w64_rdata;

    int          checks = 0;
    int          errors = 0;
    logic        exp_ready = 1'b0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    data_ram_ctrl #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(r_valid), .req_ready(w_ready), .req_we(r_we), .req_be(r_be),
        .req_addr(r_addr), .req_wdata(r_wdata),
        .resp_valid(w_rvalid), .resp_rdata(w_rdata), .resp_err(w_err),
        .init_done(w_done)
    );

    data_ram_ctrl #(.DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(r64_valid), .req_ready(w64_ready), .req_we(r64_we), .req_be(r64_be),
        .req_addr(r64_addr), .req_wdata(r64_wdata),
        .resp_valid(w64_rvalid), .resp_rdata(w64_rdata), .resp_err(w64_err),
        .init_done(w64_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic int pick_idx();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 15));
        return int'($urandom_range(496, 511));
    endfunction

    // One request, one edge; the response of that request is checked #1 later.
    task automatic do_req(input string tag, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic        acc;
        logic        err;
        logic [31:0] exp_rd;
        int          idx;
        r_valid = 1'b1; r_we = we; r_be = be; r_addr = addr; r_wdata = wdata;
        chk({tag, ".ready"}, 64'(w_ready), 64'(exp_ready));
        acc    = exp_ready;
        idx    = int'(addr >> 2);
        err    = (addr % 4 != 0) || (idx >= DEPTH);
        exp_rd = '0;
        if (!we && !err) exp_rd = model[idx];
        @(posedge clk); #1;
        r_valid = 1'b0;
        chk({tag, ".valid"}, 64'(w_rvalid), 64'(acc));
        if (acc) begin
            chk({tag, ".rdata"}, 64'(w_rdata), 64'(exp_rd));
            chk({tag, ".err"}, 64'(w_err), 64'(err));
            if (we && !err) model[idx] = (model[idx] & ~lane_mask(be)) | (wdata & lane_mask(be));
        end
    endtask

    task automatic idle(input string tag);
        r_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".valid"}, 64'(w_rvalid), 64'd0);
        chk({tag, ".rdata"}, 64'(w_rdata), 64'd0);
        chk({tag, ".err"}, 64'(w_err), 64'd0);
    endtask

    task automatic req64(input logic we, input logic [7:0] be, input logic [31:0] addr,
                         input logic [63:0] wdata);
        r64_valid = 1'b1; r64_we = we; r64_be = be; r64_addr = addr; r64_wdata = wdata;
        @(posedge clk); #1;
        r64_valid = 1'b0;
    endtask

    // Assert reset (called #1 after an edge), then release and wait out INIT.
    task automatic apply_reset();
        rst = 1'b1;
        exp_ready = 1'b0;
        #1;
        chk("rst.ready", 64'(w_ready), 64'd0);
        chk("rst.done", 64'(w_done), 64'd0);
        chk("rst.valid", 64'(w_rvalid), 64'd0);
        chk("rst.rdata", 64'(w_rdata), 64'd0);
        chk("rst.err", 64'(w_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) do_req("init", 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
`else
        do_req("init", 1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
`endif
        exp_ready = 1'b1;
        chk("run.ready", 64'(w_ready), 64'd1);
        chk("run.done", 64'(w_done), 64'd1);
        chk("run64.ready", 64'(w64_ready), 64'd1);
    endtask

    initial begin
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        int          idx;
        int          kind;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #2;
        apply_reset();

`ifdef RAM_CLEAR_ON_RESET_EN
        do_req("clr_7fc", 1'b0, 4'hF, 32'h7FC, 32'h0);
        chk("clr_7fc.const", 64'(w_rdata), 64'h0);
`endif
        for (int i = 0; i < 16; i++) begin
            do_req("pre_lo", 1'b1, 4'hF, 32'(i * 4), $urandom);
            do_req("pre_hi", 1'b1, 4'hF, 32'((496 + i) * 4), $urandom);
        end

        do_req("be_full", 1'b1, 4'hF, 32'h10, 32'hAABB_CCDD);
        do_req("be_part", 1'b1, 4'h5, 32'h10, 32'h1122_3344);
        do_req("be_read", 1'b0, 4'hF, 32'h10, 32'h0);
        chk("be_read.const", 64'(w_rdata), 64'hAA22_CC44);

        do_req("misalign", 1'b0, 4'hF, 32'h12, 32'h0);
        chk("misalign.const", 64'(w_err), 64'd1);
        do_req("oor_rd", 1'b0, 4'hF, 32'h800, 32'h0);
        chk("oor_rd.const", 64'(w_err), 64'd1);
        do_req("oor_wr", 1'b1, 4'hF, 32'h800, 32'h5555_AAAA);
        do_req("word0", 1'b0, 4'hF, 32'h0, 32'h0);

        do_req("raw_wr", 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        do_req("raw_rd", 1'b0, 4'hF, 32'h20, 32'h0);
        chk("raw_rd.const", 64'(w_rdata), 64'hDEAD_BEEF);
        idle("raw_idle");

        do_req("be0_wr", 1'b1, 4'h0, 32'h24, 32'h1234_5678);
        do_req("be0_rd", 1'b0, 4'hF, 32'h24, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle("rnd_idle");
            end else begin
                kind = int'($urandom_range(0, 9));
                idx  = pick_idx();
                we   = 1'($urandom_range(0, 1));
                be   = 4'($urandom_range(0, 15));
                case (kind)
                    0:       addr = 32'(idx * 4 + int'($urandom_range(1, 3)));
                    1:       addr = 32'((DEPTH + int'($urandom_range(0, 100000))) * 4);
                    2:       addr = $urandom | 32'h8000_0000;
                    default: addr = 32'(idx * 4);
                endcase
                do_req("rnd", we, be, addr, $urandom);
            end
        end

        req64(1'b1, 8'h80, 32'h08, 64'hFF00_0000_0000_0000);
        chk("w64_wr.valid", 64'(w64_rvalid), 64'd1);
        chk("w64_wr.err", 64'(w64_err), 64'd0);
        req64(1'b0, 8'hFF, 32'h08, 64'h0);
        chk("w64_rd.valid", 64'(w64_rvalid), 64'd1);
        chk("w64_rd.top", 64'(w64_rdata[63:56]), 64'hFF);
        chk("w64_rd.err", 64'(w64_err), 64'd0);
        req64(1'b0, 8'hFF, 32'h04, 64'h0);
        chk("w64_mis.err", 64'(w64_err), 64'd1);
        chk("w64_mis.rdata", w64_rdata, 64'h0);
        req64(1'b0, 8'hFF, 32'h80, 64'h0);
        chk("w64_oor.err", 64'(w64_err), 64'd1);

        // Read accepted on this edge; reset arrives before its response is used.
        r_valid = 1'b1; r_we = 1'b0; r_be = 4'hF; r_addr = 32'h10;
        @(posedge clk); #1;
        r_valid = 1'b0;
        apply_reset();
        for (int i = 0; i < 3; i++) idle("post_rst");
        for (int i = 0; i < 16; i++) do_req("keep", 1'b0, 4'hF, 32'(i * 4), 32'h0);
        do_req("keep_hi", 1'b0, 4'hF, 32'h7FC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
